uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  - UART transmit-side framer: accepts a parallel byte, emits a serial frame:
//    start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
//  - Generates the parity bit that the receive-side parity checker verifies.
//  - Sits between the TX data source and the TX pin. CLK is the bit-rate clock:
//    one serial bit per CLK cycle.
// PARAMETERS
//  - DATA_WIDTH  8  payload bits per frame
// PORTS
//  - CLK         in   1           bit-rate clock, rising edge
//  - RST         in   1           asynchronous, active-low reset
//  - P_DATA      in   DATA_WIDTH  parallel byte to send
//  - DATA_VALID  in   1           request: P_DATA valid this cycle
//  - PAR_EN      in   1           1 = insert parity bit
//  - PAR_TYP     in   1           1 = odd parity, 0 = even parity
//  - TX_OUT      out  1           serial line, registered, idle high
//  - BUSY        out  1           frame in progress, registered
// BEHAVIOUR
//  - Reset (async, RST=0): TX_OUT=1, BUSY=0, state=IDLE, data/parity regs=0.
//    RST asserted mid-frame abandons the frame; the line goes high immediately.
//  - FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN latched) -> STOP -> IDLE.
//  - IDLE: TX_OUT=1, BUSY=0. If DATA_VALID=1 at edge k: latch P_DATA, PAR_EN, PAR_TYP;
//    compute parity from latched data (even: ^data, odd: ~^data); go to START.
//  - Cycle k+1: START, TX_OUT=0, BUSY=1.
//  - Cycles k+2..k+1+DATA_WIDTH: DATA, TX_OUT=data[i], i=0..DATA_WIDTH-1.
//    Bit counter of width $clog2(DATA_WIDTH); it wraps to 0 on exit from DATA.
//  - PAR_EN=1: cycle k+2+DATA_WIDTH is PARITY, TX_OUT=parity bit; STOP follows.
//  - STOP: TX_OUT=1, BUSY=1 for one cycle; then IDLE (BUSY=0).
//  - Frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
//  - DATA_VALID is sampled only in IDLE. It is ignored while BUSY=1 and is not queued.
//    Minimum gap between frames: one idle (high) cycle.
//  - P_DATA, PAR_EN and PAR_TYP changes after acceptance do not affect the current frame.
//  - TX_OUT is driven from a flop, so it never glitches.
//    It is high in every state except START, DATA and PARITY.
// STRUCTURE
//  - Shared uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP),
//    PAR_ODD/PAR_EVEN constants, DATA_WIDTH default.
//  - Sub-module uart_tx_parity_gen (combinational parity over latched data + PAR_TYP).
//    The FSM, counter and output mux stay in this module.
// TESTING
//  1. RST=0 at any point -> TX_OUT=1, BUSY=0 on the next sample.
//     After release with DATA_VALID=0, the line stays 1.
//  2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> 0,1,0,1,0,0,1,0,1,0(parity),1.
//     BUSY=1 for 11 cycles.
//  3. P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> same frame, parity bit=1.
//     P_DATA=0x01, odd -> parity=0.
//  4. P_DATA=0x3C, PAR_EN=0 -> 0,0,0,1,1,1,1,0,0,1. BUSY=1 for 10 cycles.
//  5. DATA_VALID pulsed with 0xFF during DATA of a 0x00 frame -> 0x00 frame is unaltered.
//     No second frame starts; BUSY falls after STOP.
//  6. RST=0 on the 4th data bit -> TX_OUT=1, BUSY=0 at once.
//     A new request after release sends a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, parity-type constants and
// the default payload width.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PAR_ODD  = 1'b1;
    localparam logic PAR_EVEN = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_parity_gen.sv
// Combinational parity over the latched payload; the receive-side checker
// expects exactly this polarity (even: ^data, odd: ~^data).
module uart_tx_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule : uart_tx_parity_gen

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH bits LSB first, optional parity,
// stop bit. One serial bit per CLK cycle; TX_OUT and BUSY come straight from flops.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      next_idx;
    logic                  par_bit;

    // Parity depends only on the latched copy, so late input changes cannot leak in.
    uart_tx_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_r),
        .par_typ (par_typ_r),
        .par_bit (par_bit)
    );

    assign next_idx = bit_cnt + 1'b1;

    // TX_OUT is loaded with the value of the state being entered, so the pin
    // always reflects the current state without any combinational output path.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (!RST) begin
            // NOTE: every register, including the payload copy, is reset so an
            // abandoned frame leaves no stale data or parity behind.
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
            data_r    <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= PAR_EVEN;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    BUSY   <= 1'b0;
                    if (DATA_VALID) begin
                        data_r    <= P_DATA;
                        par_en_r  <= PAR_EN;
                        par_typ_r <= PAR_TYP;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        BUSY      <= 1'b1;
                    end
                end
                START: begin
                    state   <= DATA;
                    TX_OUT  <= data_r[0];
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en_r) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= next_idx;
                        TX_OUT  <= data_r[next_idx];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                end
                STOP: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    BUSY   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    TX_OUT  <= 1'b1;
                    BUSY    <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: expected line/BUSY values are queued when a
// request is driven and popped one per bit cycle against the DUT outputs.
module tb_uart_tx_frame;

    typedef struct packed {
        logic tx;
        logic busy;
    } line_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       BUSY;

    int pass_cnt = 0;
    int total_cnt = 0;

    line_t exp_q[$];

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check({tag, "_tx"}, TX_OUT, 1'b1);
            check({tag, "_busy"}, BUSY, 1'b0);
            @(negedge CLK);
        end
    endtask

    // Sends one frame. inj_at >= 0 pulses a competing 0xFF request on that
    // bit cycle; rst_at >= 0 asserts reset on that bit cycle.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic pt, input int inj_at, input int rst_at);
        line_t e;
        logic  par;
        int    idx;
        par = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
        if (pt) par = ~par;
        exp_q.push_back('{tx: 1'b0, busy: 1'b1});
        for (int i = 0; i < 8; i++) exp_q.push_back('{tx: d[i], busy: 1'b1});
        if (pe) exp_q.push_back('{tx: par, busy: 1'b1});
        exp_q.push_back('{tx: 1'b1, busy: 1'b1});

        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (idx == rst_at) begin
                RST = 1'b0;
                #1;
                check({tag, "_rst_tx"}, TX_OUT, 1'b1);
                check({tag, "_rst_busy"}, BUSY, 1'b0);
                exp_q.delete();
                @(negedge CLK);
                check({tag, "_rsthold_tx"}, TX_OUT, 1'b1);
                check({tag, "_rsthold_busy"}, BUSY, 1'b0);
                RST = 1'b1;
            end else begin
                check($sformatf("%s_bit%0d_tx", tag, idx), TX_OUT, e.tx);
                check($sformatf("%s_bit%0d_busy", tag, idx), BUSY, e.busy);
            end
            if (idx == 0) begin
                P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
            end
            if (idx == inj_at) begin
                P_DATA = 8'hFF; DATA_VALID = 1'b1;
            end else begin
                DATA_VALID = 1'b0;
            end
            idx++;
            @(negedge CLK);
        end
        DATA_VALID = 1'b0;
    endtask

    initial begin
        // Reset state and idle line after release
        @(negedge CLK);
        check("reset_tx", TX_OUT, 1'b1);
        check("reset_busy", BUSY, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        check_idle("post_reset", 3);

        // Parity frames: 0xA5 even/odd, 0x01 odd
        send_frame("a5_even", 8'hA5, 1'b1, 1'b0, -1, -1);
        check_idle("gap1", 1);
        send_frame("a5_odd", 8'hA5, 1'b1, 1'b1, -1, -1);
        check_idle("gap2", 1);
        send_frame("01_odd", 8'h01, 1'b1, 1'b1, -1, -1);
        check_idle("gap3", 1);

        // No parity frame
        send_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, -1, -1);
        check_idle("gap4", 1);

        // Competing request during DATA must be ignored and not queued
        send_frame("00_inject", 8'h00, 1'b0, 1'b0, 4, -1);
        check_idle("no_second", 4);

        // Reset on the 4th data bit, then a full frame after release
        send_frame("rst_mid", 8'h5A, 1'b1, 1'b0, -1, 4);
        check_idle("after_rst", 2);
        send_frame("c3_even", 8'hC3, 1'b1, 1'b0, -1, -1);
        check_idle("final", 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_uart_tx_frame
